// File: rtl/ls_pkg.sv
// Shared types for the load/store issue queue: widths, op encodings, the
// per-entry record and the operand wakeup helper.
package ls_pkg;

    localparam int LS_TAG_W  = 6;
    localparam int LS_CW_W   = 4;
    localparam int LS_OP_W   = 6;
    localparam int LS_DATA_W = 32;

    typedef enum logic [LS_OP_W-1:0] {
        LS_LB  = 6'h00,
        LS_LH  = 6'h01,
        LS_LW  = 6'h02,
        LS_LBU = 6'h04,
        LS_LHU = 6'h05,
        LS_SB  = 6'h08,
        LS_SH  = 6'h09,
        LS_SW  = 6'h0A
    } ls_op_e;

    typedef struct packed {
        logic                 valid;
        logic [LS_OP_W-1:0]   op;
        logic [LS_DATA_W-1:0] imm;
        logic [LS_TAG_W-1:0]  s1_tag;
        logic                 s1_rdy;
        logic [LS_DATA_W-1:0] s1_val;
        logic [LS_TAG_W-1:0]  s2_tag;
        logic                 s2_rdy;
        logic [LS_DATA_W-1:0] s2_val;
        logic [LS_TAG_W-1:0]  rdst;
        logic [LS_CW_W-1:0]   cw;
    } ls_entry_t;

    // A source already marked ready keeps its value; only waiting sources capture.
    function automatic ls_entry_t ls_wakeup(input ls_entry_t            e,
                                            input logic                 hit,
                                            input logic [LS_TAG_W-1:0]  tag,
                                            input logic [LS_DATA_W-1:0] data);
        ls_entry_t r;
        r = e;
        if (hit && !e.s1_rdy && (e.s1_tag == tag)) begin
            r.s1_rdy = 1'b1;
            r.s1_val = data;
        end else begin
            r.s1_rdy = e.s1_rdy;
        end
        if (hit && !e.s2_rdy && (e.s2_tag == tag)) begin
            r.s2_rdy = 1'b1;
            r.s2_val = data;
        end else begin
            r.s2_rdy = e.s2_rdy;
        end
        return r;
    endfunction

endpackage

// File: rtl/ls_issue_queue_if.sv
// Bus bundle between the dispatch/writeback side and the load/store issue
// queue, including the EX_DU issue port.
interface ls_issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6,
    parameter int CW_W  = 4
);
    logic                   flush;

    logic                   disp_valid;
    logic                   disp_ready;
    logic [5:0]             disp_op;
    logic [31:0]            disp_imm;
    logic [TAG_W-1:0]       disp_s1_tag;
    logic                   disp_s1_rdy;
    logic [31:0]            disp_s1_val;
    logic [TAG_W-1:0]       disp_s2_tag;
    logic                   disp_s2_rdy;
    logic [31:0]            disp_s2_val;
    logic [TAG_W-1:0]       disp_rdst;
    logic [CW_W-1:0]        disp_cw;

    logic                   wb_valid;
    logic                   wb_write_phy;
    logic [TAG_W-1:0]       wb_tag;
    logic [31:0]            wb_data;

    logic                   ex_en;
    logic [5:0]             ex_operation;
    logic [31:0]            ex_imm;
    logic [31:0]            ex_src1;
    logic [31:0]            ex_src2;
    logic [TAG_W-1:0]       ex_phy_rdst;
    logic [CW_W-1:0]        ex_commit_window;

    logic [$clog2(DEPTH):0] count;

    modport master (
        output flush,
        output disp_valid, disp_op, disp_imm, disp_s1_tag, disp_s1_rdy, disp_s1_val,
        output disp_s2_tag, disp_s2_rdy, disp_s2_val, disp_rdst, disp_cw,
        output wb_valid, wb_write_phy, wb_tag, wb_data,
        input  disp_ready,
        input  ex_en, ex_operation, ex_imm, ex_src1, ex_src2, ex_phy_rdst, ex_commit_window,
        input  count
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_op, disp_imm, disp_s1_tag, disp_s1_rdy, disp_s1_val,
        input  disp_s2_tag, disp_s2_rdy, disp_s2_val, disp_rdst, disp_cw,
        input  wb_valid, wb_write_phy, wb_tag, wb_data,
        output disp_ready,
        output ex_en, ex_operation, ex_imm, ex_src1, ex_src2, ex_phy_rdst, ex_commit_window,
        output count
    );

endinterface

// File: rtl/ls_iq_entry.sv
// One issue-queue slot: holds a dispatched memory op and captures waiting
// source operands from the writeback broadcast.
module ls_iq_entry
    import ls_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  ls_entry_t            wr_data,
    input  logic                 pop,
    input  logic                 wb_hit,
    input  logic [LS_TAG_W-1:0]  wb_tag,
    input  logic [LS_DATA_W-1:0] wb_data,
    output ls_entry_t            entry
);

    ls_entry_t entry_d;
    ls_entry_t entry_q;

    // Write and pop never target the same slot in one cycle: that needs
    // head==tail, i.e. an empty queue (nothing to pop) or a full one (no write).
    always_comb begin
        entry_d = entry_q;
        if (wr_en) begin
            entry_d = ls_wakeup(wr_data, wb_hit, wb_tag, wb_data);
        end else if (pop) begin
            entry_d.valid  = 1'b0;
            entry_d.s1_rdy = 1'b0;
            entry_d.s2_rdy = 1'b0;
        end else if (entry_q.valid) begin
            entry_d = ls_wakeup(entry_q, wb_hit, wb_tag, wb_data);
        end else begin
            entry_d = entry_q;
        end
    end

    // Slot register; flush clears it like reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: circular buffer of ls_iq_entry slots that
// issues only from the head once both operands are ready.
module ls_issue_queue
    import ls_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = LS_TAG_W,
    parameter int CW_W  = LS_CW_W
) (
    input  logic             clk,
    input  logic             rst,
    ls_issue_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             disp_ready_q, disp_ready_d;

    logic             ex_en_q, ex_en_d;
    logic [5:0]       ex_op_q, ex_op_d;
    logic [31:0]      ex_imm_q, ex_imm_d;
    logic [31:0]      ex_src1_q, ex_src1_d;
    logic [31:0]      ex_src2_q, ex_src2_d;
    logic [TAG_W-1:0] ex_rdst_q, ex_rdst_d;
    logic [CW_W-1:0]  ex_cw_q, ex_cw_d;

    ls_entry_t        ent_s [DEPTH];
    ls_entry_t        head_ent_s;
    ls_entry_t        wr_entry_s;
    logic [DEPTH-1:0] wr_en_s;
    logic [DEPTH-1:0] pop_s;
    logic             accept_s;
    logic             issue_s;
    logic             wb_hit_s;

    // Fullness comes from the registered ready flag, so a same-cycle issue
    // never frees room for a dispatch.
    assign accept_s   = bus.disp_valid & disp_ready_q & ~bus.flush;
    assign head_ent_s = ent_s[head_q];
    assign issue_s    = head_ent_s.valid & head_ent_s.s1_rdy & head_ent_s.s2_rdy & ~bus.flush;
    assign wb_hit_s   = bus.wb_valid & bus.wb_write_phy;

    // Assemble the record written at the tail.
    always_comb begin
        wr_entry_s        = '0;
        wr_entry_s.valid  = 1'b1;
        wr_entry_s.op     = bus.disp_op;
        wr_entry_s.imm    = bus.disp_imm;
        wr_entry_s.s1_tag = bus.disp_s1_tag;
        wr_entry_s.s1_rdy = bus.disp_s1_rdy;
        wr_entry_s.s1_val = bus.disp_s1_val;
        wr_entry_s.s2_tag = bus.disp_s2_tag;
        wr_entry_s.s2_rdy = bus.disp_s2_rdy;
        wr_entry_s.s2_val = bus.disp_s2_val;
        wr_entry_s.rdst   = bus.disp_rdst;
        wr_entry_s.cw     = bus.disp_cw;
    end

    // One-hot slot selects for the tail write and the head pop.
    always_comb begin
        wr_en_s = '0;
        pop_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en_s[i] = accept_s & (tail_q == PTR_W'(i));
            pop_s[i]   = issue_s & (head_q == PTR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        ls_iq_entry u_entry (
            .clk     (clk),
            .rst     (rst),
            .clr     (bus.flush),
            .wr_en   (wr_en_s[g]),
            .wr_data (wr_entry_s),
            .pop     (pop_s[g]),
            .wb_hit  (wb_hit_s),
            .wb_tag  (bus.wb_tag),
            .wb_data (bus.wb_data),
            .entry   (ent_s[g])
        );
    end

    // Pointer, occupancy and ready-flag next state.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (issue_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (accept_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({accept_s, issue_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        disp_ready_d = (count_d != CNT_W'(DEPTH));
    end

    // Issue register: loads the head on issue, otherwise holds with ex_en low.
    always_comb begin
        ex_en_d   = issue_s;
        ex_op_d   = ex_op_q;
        ex_imm_d  = ex_imm_q;
        ex_src1_d = ex_src1_q;
        ex_src2_d = ex_src2_q;
        ex_rdst_d = ex_rdst_q;
        ex_cw_d   = ex_cw_q;
        if (issue_s) begin
            ex_op_d   = head_ent_s.op;
            ex_imm_d  = head_ent_s.imm;
            ex_src1_d = head_ent_s.s1_val;
            ex_src2_d = head_ent_s.s2_val;
            ex_rdst_d = head_ent_s.rdst;
            ex_cw_d   = head_ent_s.cw;
        end else begin
            ex_op_d   = ex_op_q;
        end
    end

    // Control and issue-port registers; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            disp_ready_q <= 1'b1;
            ex_en_q      <= 1'b0;
            ex_op_q      <= '0;
            ex_imm_q     <= '0;
            ex_src1_q    <= '0;
            ex_src2_q    <= '0;
            ex_rdst_q    <= '0;
            ex_cw_q      <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            disp_ready_q <= disp_ready_d;
            ex_en_q      <= ex_en_d;
            ex_op_q      <= ex_op_d;
            ex_imm_q     <= ex_imm_d;
            ex_src1_q    <= ex_src1_d;
            ex_src2_q    <= ex_src2_d;
            ex_rdst_q    <= ex_rdst_d;
            ex_cw_q      <= ex_cw_d;
        end
    end

    assign bus.disp_ready       = disp_ready_q;
    assign bus.count            = count_q;
    assign bus.ex_en            = ex_en_q;
    assign bus.ex_operation     = ex_op_q;
    assign bus.ex_imm           = ex_imm_q;
    assign bus.ex_src1          = ex_src1_q;
    assign bus.ex_src2          = ex_src2_q;
    assign bus.ex_phy_rdst      = ex_rdst_q;
    assign bus.ex_commit_window = ex_cw_q;

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed bench for ls_issue_queue: hand-computed expectations for issue,
// wakeup, same-cycle capture, head blocking, full/wrap, flush and reset.
module tb_ls_issue_queue;
    import ls_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ls_issue_queue_if #(.DEPTH(8), .TAG_W(6), .CW_W(4)) bus ();

    ls_issue_queue #(.DEPTH(8), .TAG_W(6), .CW_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.disp_valid   = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_write_phy = 1'b0;
    endtask

    task automatic drive_disp(input logic [5:0] op, input logic [31:0] imm,
                              input logic [5:0] s1_tag, input logic s1_rdy, input logic [31:0] s1_val,
                              input logic [5:0] s2_tag, input logic s2_rdy, input logic [31:0] s2_val,
                              input logic [5:0] rdst, input logic [3:0] cw);
        bus.disp_valid  = 1'b1;
        bus.disp_op     = op;
        bus.disp_imm    = imm;
        bus.disp_s1_tag = s1_tag;
        bus.disp_s1_rdy = s1_rdy;
        bus.disp_s1_val = s1_val;
        bus.disp_s2_tag = s2_tag;
        bus.disp_s2_rdy = s2_rdy;
        bus.disp_s2_val = s2_val;
        bus.disp_rdst   = rdst;
        bus.disp_cw     = cw;
    endtask

    task automatic drive_wb(input logic [5:0] tag, input logic [31:0] data);
        bus.wb_valid     = 1'b1;
        bus.wb_write_phy = 1'b1;
        bus.wb_tag       = tag;
        bus.wb_data      = data;
    endtask

    // Fill 6 waiting entries, issue one, then clear with flush or rst while
    // a ready dispatch and a wakeup are presented in the same cycle.
    task automatic run_clear(input bit use_rst, input string nm);
        for (int i = 0; i < 6; i++) begin
            drive_disp(LS_LW, 32'h0, 6'(50 + i), 1'b0, 32'h0, 6'd1, 1'b1, 32'h0, 6'(40 + i), 4'd1);
            tick();
        end
        idle();
        drive_wb(6'd50, 32'h5A5A);
        tick();
        idle();
        tick();
        check_eq({nm, "_pre_en"}, 32'(bus.ex_en), 32'd1);
        check_eq({nm, "_pre_cnt"}, 32'(bus.count), 32'd5);
        drive_disp(LS_LW, 32'h0, 6'd2, 1'b1, 32'h1234, 6'd3, 1'b1, 32'h0, 6'd60, 4'd2);
        drive_wb(6'd51, 32'h6666);
        if (use_rst) rst = 1'b1;
        else bus.flush = 1'b1;
        tick();
        rst = 1'b0;
        bus.flush = 1'b0;
        idle();
        check_eq({nm, "_cnt"}, 32'(bus.count), 32'd0);
        check_eq({nm, "_en"}, 32'(bus.ex_en), 32'd0);
        check_eq({nm, "_rdy"}, 32'(bus.disp_ready), 32'd1);
        check_eq({nm, "_src1"}, bus.ex_src1, 32'h0);
        check_eq({nm, "_rdst"}, 32'(bus.ex_phy_rdst), 32'd0);
        tick();
        check_eq({nm, "_drop_en"}, 32'(bus.ex_en), 32'd0);
        check_eq({nm, "_drop_cnt"}, 32'(bus.count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        idle();
        drive_disp(LS_LB, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 4'd0);
        bus.disp_valid = 1'b0;
        bus.wb_tag  = 6'd0;
        bus.wb_data = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_en", 32'(bus.ex_en), 32'd0);
        check_eq("rst_cnt", 32'(bus.count), 32'd0);
        check_eq("rst_rdy", 32'(bus.disp_ready), 32'd1);

        // Both operands ready at dispatch.
        drive_disp(LS_LW, 32'h4, 6'd1, 1'b1, 32'h100, 6'd2, 1'b1, 32'h0, 6'd5, 4'd3);
        tick();
        idle();
        check_eq("t1_cnt1", 32'(bus.count), 32'd1);
        check_eq("t1_en0", 32'(bus.ex_en), 32'd0);
        tick();
        check_eq("t1_en", 32'(bus.ex_en), 32'd1);
        check_eq("t1_op", 32'(bus.ex_operation), 32'(LS_LW));
        check_eq("t1_imm", bus.ex_imm, 32'h4);
        check_eq("t1_src1", bus.ex_src1, 32'h100);
        check_eq("t1_rdst", 32'(bus.ex_phy_rdst), 32'd5);
        check_eq("t1_cw", 32'(bus.ex_commit_window), 32'd3);
        check_eq("t1_cnt0", 32'(bus.count), 32'd0);
        tick();
        check_eq("t1_hold_en", 32'(bus.ex_en), 32'd0);
        check_eq("t1_hold_src1", bus.ex_src1, 32'h100);

        // Wakeup; a broadcast without write_phy must be ignored.
        drive_disp(LS_LW, 32'h0, 6'd9, 1'b0, 32'h0, 6'd2, 1'b1, 32'h7, 6'd6, 4'd1);
        tick();
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'd9;
        bus.wb_data  = 32'hBAD;
        tick();
        idle();
        tick();
        check_eq("t2_nophy_en", 32'(bus.ex_en), 32'd0);
        drive_wb(6'd9, 32'hDEAD);
        tick();
        idle();
        check_eq("t2_nobypass_en", 32'(bus.ex_en), 32'd0);
        tick();
        check_eq("t2_en", 32'(bus.ex_en), 32'd1);
        check_eq("t2_src1", bus.ex_src1, 32'hDEAD);
        check_eq("t2_src2", bus.ex_src2, 32'h7);

        // Same-cycle capture at dispatch.
        drive_disp(LS_SW, 32'h8, 6'd1, 1'b1, 32'h10, 6'd12, 1'b0, 32'h0, 6'd0, 4'd2);
        drive_wb(6'd12, 32'h55);
        tick();
        idle();
        tick();
        check_eq("t3_en", 32'(bus.ex_en), 32'd1);
        check_eq("t3_op", 32'(bus.ex_operation), 32'(LS_SW));
        check_eq("t3_src2", bus.ex_src2, 32'h55);
        check_eq("t3_src1", bus.ex_src1, 32'h10);

        // A source ready at dispatch keeps its value despite a matching broadcast.
        drive_disp(LS_LW, 32'h0, 6'd3, 1'b1, 32'h11, 6'd4, 1'b1, 32'h44, 6'd8, 4'd5);
        drive_wb(6'd3, 32'h99);
        tick();
        idle();
        tick();
        check_eq("t3b_src1", bus.ex_src1, 32'h11);

        // Head blocks a younger ready entry.
        drive_disp(LS_LW, 32'h0, 6'd7, 1'b0, 32'h0, 6'd1, 1'b1, 32'h0, 6'd10, 4'd6);
        tick();
        drive_disp(LS_LW, 32'h0, 6'd8, 1'b1, 32'h22, 6'd1, 1'b1, 32'h0, 6'd11, 4'd7);
        tick();
        idle();
        tick();
        check_eq("t4_block_en", 32'(bus.ex_en), 32'd0);
        check_eq("t4_cnt2", 32'(bus.count), 32'd2);
        drive_wb(6'd7, 32'h77);
        tick();
        idle();
        check_eq("t4_wake_en", 32'(bus.ex_en), 32'd0);
        tick();
        check_eq("t4_head_en", 32'(bus.ex_en), 32'd1);
        check_eq("t4_head_rdst", 32'(bus.ex_phy_rdst), 32'd10);
        check_eq("t4_head_src1", bus.ex_src1, 32'h77);
        tick();
        check_eq("t4_next_en", 32'(bus.ex_en), 32'd1);
        check_eq("t4_next_rdst", 32'(bus.ex_phy_rdst), 32'd11);
        check_eq("t4_cnt0", 32'(bus.count), 32'd0);

        // Full queue from pointer 0, rejected 9th dispatch, wrap to slot 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_disp(LS_LB, 32'h0, 6'(20 + i), 1'b0, 32'h0, 6'd1, 1'b1, 32'h0, 6'(i), 4'd0);
            tick();
        end
        idle();
        check_eq("t5_full_cnt", 32'(bus.count), 32'd8);
        check_eq("t5_full_rdy", 32'(bus.disp_ready), 32'd0);
        drive_wb(6'd20, 32'hA0);
        tick();
        idle();
        check_eq("t5_wake_en", 32'(bus.ex_en), 32'd0);
        drive_disp(LS_LW, 32'h0, 6'd1, 1'b1, 32'h0, 6'd1, 1'b1, 32'h0, 6'd30, 4'd0);
        tick();
        idle();
        check_eq("t5_iss_en", 32'(bus.ex_en), 32'd1);
        check_eq("t5_iss_rdst", 32'(bus.ex_phy_rdst), 32'd0);
        check_eq("t5_iss_src1", bus.ex_src1, 32'hA0);
        check_eq("t5_rej_cnt", 32'(bus.count), 32'd7);
        check_eq("t5_rej_rdy", 32'(bus.disp_ready), 32'd1);
        drive_disp(LS_LW, 32'h0, 6'd1, 1'b1, 32'h31, 6'd1, 1'b1, 32'h0, 6'd31, 4'd0);
        drive_wb(6'd21, 32'h1);
        tick();
        bus.disp_valid = 1'b0;
        check_eq("t5_wrap_en", 32'(bus.ex_en), 32'd0);
        check_eq("t5_wrap_cnt", 32'(bus.count), 32'd8);
        check_eq("t5_wrap_rdy", 32'(bus.disp_ready), 32'd0);
        for (int k = 2; k < 8; k++) begin
            drive_wb(6'(20 + k), 32'(k));
            tick();
            check_eq("t5_seq_en", 32'(bus.ex_en), 32'd1);
            check_eq("t5_seq_rdst", 32'(bus.ex_phy_rdst), 32'(k - 1));
        end
        idle();
        tick();
        check_eq("t5_last_rdst", 32'(bus.ex_phy_rdst), 32'd7);
        tick();
        check_eq("t5_slot0_en", 32'(bus.ex_en), 32'd1);
        check_eq("t5_slot0_rdst", 32'(bus.ex_phy_rdst), 32'd31);
        check_eq("t5_slot0_src1", bus.ex_src1, 32'h31);
        tick();
        check_eq("t5_empty_en", 32'(bus.ex_en), 32'd0);
        check_eq("t5_empty_cnt", 32'(bus.count), 32'd0);

        run_clear(1'b0, "flush");
        run_clear(1'b1, "rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
